riscv_soft_load_scoreboard: RTL and testbench
=============================================

Name: riscv_soft_load_scoreboard

Overview:
Parametrised register scoreboard and in-order pending-load queue for the riscv-soft pipeline. It replaces the single-entry WB-stage load-use check with up to MAX_OUTSTANDING loads in flight against a multi-cycle dcache. It tracks pending destination registers, raises RAW, WAW and queue-full stalls for the EX stage, and forwards returning load data to the EX operands. It also issues the register-file write for each returning load.

Parameters:
XPR_LEN, 32, data path width
NUM_REGS, 32, architectural registers; REG_W = clog2(NUM_REGS)
MAX_OUTSTANDING, 4, pending-load queue depth (>=1, not required to be a power of 2); CNT_W = clog2(MAX_OUTSTANDING+1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
issue_valid_EX  in  1  EX instruction graduates this cycle; upstream already qualifies it with !stall_EX and !kill
issue_wr_reg_EX  in  1  graduating instruction writes rd
issue_is_load_EX  in  1  graduating instruction is a load (long latency)
issue_rd_EX  in  REG_W  destination register
rs1_EX, rs2_EX  in  REG_W each  source registers of the instruction currently in EX
rs1_used_EX, rs2_used_EX  in  1 each  the corresponding source is read
dcache_resp_valid  in  1  load response; responses return in issue order
dcache_resp_data  in  XPR_LEN  load data
stall_EX  out  1  OR of stall_raw_EX, stall_waw_EX, stall_full_EX
stall_raw_EX, stall_waw_EX, stall_full_EX  out  1 each  individual stall causes
fwd_rs1_EX, fwd_rs2_EX  out  1 each  select dcache_resp_data for the operand
wb_valid_LQ  out  1  write a load result this cycle
wb_rd_LQ  out  REG_W  load writeback register
wb_data_LQ  out  XPR_LEN  equals dcache_resp_data
outstanding_cnt  out  CNT_W  loads in flight
lq_empty, lq_full  out  1 each  queue status
protocol_err  out  1  sticky: a response arrived with the queue empty

Behaviour:
- State:
  - pending[NUM_REGS] bit vector.
  - Circular queue of {rd, wr} entries with head and tail pointers. Each pointer wraps from MAX_OUTSTANDING-1 to 0 explicitly.
  - outstanding_cnt.
- Reset (async, reset==0): pending all 0, pointers 0, outstanding_cnt 0, protocol_err 0.
- Outputs after reset: every stall 0, fwd 0, wb_valid_LQ 0, lq_empty 1, lq_full 0.
- Pop: occurs when dcache_resp_valid && !lq_empty. It advances head and clears pending[head.rd] if head.wr.
- Writeback: wb_valid_LQ = pop && head.wr && head.rd!=0. wb_rd_LQ = head.rd. The path is combinational, with zero latency from the response.
- Push: occurs when issue_valid_EX && issue_is_load_EX. Entry wr = issue_wr_reg_EX && issue_rd_EX!=0. Sets pending[rd] if wr. Loads to x0 are still queued so that responses stay matched.
- Non-load issues never touch the queue or pending.
- Same-cycle pop and push:
  - Allowed, including when full; outstanding_cnt is unchanged.
  - If both target the same rd, the set from the push wins, so pending stays 1.
- resolve(r) = pop && head.wr && head.rd==r.
- Forwarding: fwd_rsN_EX = rsN_used_EX && rsN_EX!=0 && pending[rsN_EX] && resolve(rsN_EX).
- stall_raw_EX: some used source s!=0 has pending[s] && !resolve(s).
- stall_waw_EX: the EX instruction writes rd!=0 (any type) with pending[rd] && !resolve(rd). Short ops must not overtake an older load's writeback.
- stall_full_EX: the EX instruction is a load && lq_full && !pop.
- Stall inputs: all stalls are computed combinationally from current state plus the EX-stage fields. The issue_* fields are presented every cycle. issue_valid_EX is only the graduation qualifier, and the stall is computed with it deasserted.
- Consequence: at most one outstanding load per register.
- Response with an empty queue: ignored (no pop, no writeback). protocol_err is set and holds until reset.
- lq_full = (outstanding_cnt==MAX_OUTSTANDING). lq_empty = (outstanding_cnt==0).
- Reset asserted mid-operation discards all in-flight entries. Later stray responses set protocol_err.
- Register x0 is never pending, never stalls and never forwards.

Test Plan:
- Load x5, then `add x6,x5,x1` next cycle, response 3 cycles later with data 0xDEADBEEF -> stall_raw_EX=1 for 3 cycles; in the response cycle fwd_rs1_EX=1, wb_valid_LQ=1, wb_rd_LQ=5, stall_EX=0.
- Issue 4 loads (x1..x4) with no responses, then a 5th load -> stall_full_EX=1, outstanding_cnt=4, lq_full=1. A response in the same cycle removes the stall and the 5th pushes, with cnt staying at 4.
- Load x7 outstanding, then `addi x7,x0,1` -> stall_waw_EX=1 until the x7 response. In that cycle the addi issues with stall_waw_EX=0.
- Load to x0, then a response -> no pending bit, wb_valid_LQ=0, queue pops, outstanding_cnt returns to 0.
- dcache_resp_valid pulsed with an empty queue -> protocol_err=1 and it stays 1. Async reset low mid-cycle -> protocol_err=0 and cnt=0 immediately.
- MAX_OUTSTANDING=3: 10 back-to-back load/response pairs with distinct rd -> pointers wrap, and wb_rd_LQ sequence matches issue order.

Source files
------------

// File: rtl/riscv_soft_load_scoreboard.sv
// riscv_soft_load_scoreboard
//   Register scoreboard plus in-order pending-load queue. It allows up to
//   MAX_OUTSTANDING loads in flight against a multi-cycle dcache. The block
//   raises RAW/WAW/queue-full stalls for EX, forwards returning load data to
//   the EX operands, and drives the register-file write for each returning load.
//
// Ports
//   clk, reset                 clock, async active-low reset
//   issue_*_EX                 graduating EX instruction (valid = graduation
//                              qualifier; the other fields are always presented)
//   rs1/rs2_EX, rs*_used_EX    sources of the instruction in EX
//   dcache_resp_valid/data     in-order load responses
//   stall_*_EX                 stall causes and their OR
//   fwd_rs1/rs2_EX             select dcache_resp_data for the operand
//   wb_valid/rd/data_LQ        load writeback port
//   outstanding_cnt, lq_empty, lq_full, protocol_err   status
module riscv_soft_load_scoreboard #(
  parameter int XPR_LEN         = 32,
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int REG_W          = $clog2(NUM_REGS),
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid_EX,
  input  logic               issue_wr_reg_EX,
  input  logic               issue_is_load_EX,
  input  logic [REG_W-1:0]   issue_rd_EX,
  input  logic [REG_W-1:0]   rs1_EX,
  input  logic [REG_W-1:0]   rs2_EX,
  input  logic               rs1_used_EX,
  input  logic               rs2_used_EX,
  input  logic               dcache_resp_valid,
  input  logic [XPR_LEN-1:0] dcache_resp_data,
  output logic               stall_EX,
  output logic               stall_raw_EX,
  output logic               stall_waw_EX,
  output logic               stall_full_EX,
  output logic               fwd_rs1_EX,
  output logic               fwd_rs2_EX,
  output logic               wb_valid_LQ,
  output logic [REG_W-1:0]   wb_rd_LQ,
  output logic [XPR_LEN-1:0] wb_data_LQ,
  output logic [CNT_W-1:0]   outstanding_cnt,
  output logic               lq_empty,
  output logic               lq_full,
  output logic               protocol_err
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0]        pending_q, pending_d;
  logic [REG_W-1:0]           lq_rd_q [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] lq_wr_q;
  logic [PTR_W-1:0]           head_q, tail_q;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       perr_q;

  logic             pop, push, push_wr, head_wr;
  logic [REG_W-1:0] head_rd;
  logic             res_rs1, res_rs2, res_rd;
  logic             src1_pend, src2_pend;

  assign lq_empty = (cnt_q == '0);
  assign lq_full  = (cnt_q == CNT_MAX);

  assign head_rd = lq_rd_q[head_q];
  assign head_wr = lq_wr_q[head_q];

  // A response against an empty queue is dropped and only flags protocol_err.
  assign pop     = dcache_resp_valid && !lq_empty;
  // The full guard keeps an unqualified push from overrunning the ring;
  // a push into a full queue is fine when a pop frees the head slot.
  assign push    = issue_valid_EX && issue_is_load_EX && (!lq_full || pop);
  // Loads to x0 still take a slot so that responses stay matched.
  assign push_wr = issue_wr_reg_EX && (issue_rd_EX != '0);

  // A register resolves this cycle when the head entry writes it and pops.
  assign res_rs1 = pop && head_wr && (head_rd == rs1_EX);
  assign res_rs2 = pop && head_wr && (head_rd == rs2_EX);
  assign res_rd  = pop && head_wr && (head_rd == issue_rd_EX);

  assign src1_pend = rs1_used_EX && (rs1_EX != '0) && pending_q[rs1_EX];
  assign src2_pend = rs2_used_EX && (rs2_EX != '0) && pending_q[rs2_EX];

  assign fwd_rs1_EX    = src1_pend && res_rs1;
  assign fwd_rs2_EX    = src2_pend && res_rs2;
  assign stall_raw_EX  = (src1_pend && !res_rs1) || (src2_pend && !res_rs2);
  // Any writer (not only loads) must wait so it cannot be overwritten later
  // by an older load's writeback.
  assign stall_waw_EX  = issue_wr_reg_EX && (issue_rd_EX != '0) &&
                         pending_q[issue_rd_EX] && !res_rd;
  assign stall_full_EX = issue_is_load_EX && lq_full && !pop;
  assign stall_EX      = stall_raw_EX || stall_waw_EX || stall_full_EX;

  assign wb_valid_LQ     = pop && head_wr && (head_rd != '0);
  assign wb_rd_LQ        = head_rd;
  assign wb_data_LQ      = dcache_resp_data;
  assign outstanding_cnt = cnt_q;
  assign protocol_err    = perr_q;

  // Clear first, set second: a same-cycle push to the popping rd keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (pop && head_wr) pending_d[head_rd] = 1'b0;
    if (push && push_wr) pending_d[issue_rd_EX] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      perr_q    <= 1'b0;
      lq_wr_q   <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) lq_rd_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      if (dcache_resp_valid && lq_empty) perr_q <= 1'b1;
      if (pop) head_q <= (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
      if (push) begin
        lq_rd_q[tail_q] <= issue_rd_EX;
        lq_wr_q[tail_q] <= push_wr;
        tail_q          <= (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_soft_load_scoreboard.sv
module tb_riscv_soft_load_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: MAX_OUTSTANDING = 4
  logic        iv, iwr, ild, u1, u2, rv;
  logic [4:0]  ird, rs1, rs2;
  logic [31:0] rdata;
  logic        st, sraw, swaw, sfull, f1, f2, wbv, emp, ful, perr;
  logic [4:0]  wbrd;
  logic [31:0] wbd;
  logic [2:0]  cnt;

  // DUT B: MAX_OUTSTANDING = 3
  logic        iv2, iwr2, ild2, rv2;
  logic [4:0]  ird2;
  logic [31:0] rdata2;
  logic        st2, sraw2, swaw2, sfull2, f12, f22, wbv2, emp2, ful2, perr2;
  logic [4:0]  wbrd2;
  logic [31:0] wbd2;
  logic [1:0]  cnt2;

  riscv_soft_load_scoreboard #(.XPR_LEN(32), .NUM_REGS(32), .MAX_OUTSTANDING(4)) dut_a (
    .clk(clk), .reset(rst_n),
    .issue_valid_EX(iv), .issue_wr_reg_EX(iwr), .issue_is_load_EX(ild), .issue_rd_EX(ird),
    .rs1_EX(rs1), .rs2_EX(rs2), .rs1_used_EX(u1), .rs2_used_EX(u2),
    .dcache_resp_valid(rv), .dcache_resp_data(rdata),
    .stall_EX(st), .stall_raw_EX(sraw), .stall_waw_EX(swaw), .stall_full_EX(sfull),
    .fwd_rs1_EX(f1), .fwd_rs2_EX(f2),
    .wb_valid_LQ(wbv), .wb_rd_LQ(wbrd), .wb_data_LQ(wbd),
    .outstanding_cnt(cnt), .lq_empty(emp), .lq_full(ful), .protocol_err(perr));

  riscv_soft_load_scoreboard #(.XPR_LEN(32), .NUM_REGS(32), .MAX_OUTSTANDING(3)) dut_b (
    .clk(clk), .reset(rst_n),
    .issue_valid_EX(iv2), .issue_wr_reg_EX(iwr2), .issue_is_load_EX(ild2), .issue_rd_EX(ird2),
    .rs1_EX(5'd0), .rs2_EX(5'd0), .rs1_used_EX(1'b0), .rs2_used_EX(1'b0),
    .dcache_resp_valid(rv2), .dcache_resp_data(rdata2),
    .stall_EX(st2), .stall_raw_EX(sraw2), .stall_waw_EX(swaw2), .stall_full_EX(sfull2),
    .fwd_rs1_EX(f12), .fwd_rs2_EX(f22),
    .wb_valid_LQ(wbv2), .wb_rd_LQ(wbrd2), .wb_data_LQ(wbd2),
    .outstanding_cnt(cnt2), .lq_empty(emp2), .lq_full(ful2), .protocol_err(perr2));

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wb_t;

  wb_t qa[$];
  wb_t qb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    iv = 0; iwr = 0; ild = 0; ird = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0;
    rv = 0; rdata = 0;
    iv2 = 0; iwr2 = 0; ild2 = 0; ird2 = 0; rv2 = 0; rdata2 = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Graduating load on DUT A; the expected writeback is queued at issue.
  task automatic load_a(input logic [4:0] rd, input logic [31:0] d);
    iv = 1; ild = 1; iwr = 1; ird = rd;
    if (rd != 0) qa.push_back('{rd: rd, d: d});
  endtask

  // Writeback monitors: every wb_valid pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && wbv) begin
      if (qa.size() == 0) chk("a_unexpected_wb", {27'd0, wbrd}, 32'hFFFF_FFFF);
      else begin
        wb_t e;
        e = qa.pop_front();
        chk("a_wb_rd", {27'd0, wbrd}, {27'd0, e.rd});
        chk("a_wb_data", wbd, e.d);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && wbv2) begin
      if (qb.size() == 0) chk("b_unexpected_wb", {27'd0, wbrd2}, 32'hFFFF_FFFF);
      else begin
        wb_t e;
        e = qb.pop_front();
        chk("b_wb_rd", {27'd0, wbrd2}, {27'd0, e.rd});
        chk("b_wb_data", wbd2, e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] drain [4];
    drain[0] = 32'h2222_2222; drain[1] = 32'h3333_3333;
    drain[2] = 32'h4444_4444; drain[3] = 32'h8888_8888;

    // Reset state
    idle();
    #12;
    chk("rst_stall", {31'd0, st}, 0);
    chk("rst_fwd", {30'd0, f1, f2}, 0);
    chk("rst_wbv", {31'd0, wbv}, 0);
    chk("rst_empty", {31'd0, emp}, 1);
    chk("rst_full", {31'd0, ful}, 0);
    chk("rst_cnt", {29'd0, cnt}, 0);
    chk("rst_perr", {31'd0, perr}, 0);
    step();
    rst_n = 1;

    // RAW: load x5, add x6,x5,x1 stalls 3 cycles, forwarded on response
    idle(); load_a(5, 32'hDEAD_BEEF);
    smp(); chk("raw_load_issue_stall", {31'd0, st}, 0);
    step();
    idle(); iwr = 1; ird = 6; rs1 = 5; rs2 = 1; u1 = 1; u2 = 1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("raw_stall", {31'd0, sraw}, 1);
      chk("raw_stall_any", {31'd0, st}, 1);
      chk("raw_no_fwd", {31'd0, f1}, 0);
      step();
    end
    rv = 1; rdata = 32'hDEAD_BEEF; iv = 1;
    smp();
    chk("raw_resolve_raw", {31'd0, sraw}, 0);
    chk("raw_resolve_stall", {31'd0, st}, 0);
    chk("raw_fwd1", {31'd0, f1}, 1);
    chk("raw_fwd2", {31'd0, f2}, 0);
    chk("raw_wbv", {31'd0, wbv}, 1);
    step();
    idle(); smp();
    chk("raw_cnt_after", {29'd0, cnt}, 0);
    chk("raw_empty_after", {31'd0, emp}, 1);
    step();

    // Queue full: x1..x4 outstanding, 5th load stalls until a response
    for (int r = 1; r <= 4; r++) begin
      idle(); load_a(5'(r), 32'h1111_1111 * r);
      smp(); chk("full_fill_nostall", {31'd0, sfull}, 0);
      step();
    end
    idle(); ild = 1; iwr = 1; ird = 8;
    smp();
    chk("full_stall", {31'd0, sfull}, 1);
    chk("full_stall_any", {31'd0, st}, 1);
    chk("full_cnt", {29'd0, cnt}, 4);
    chk("full_flag", {31'd0, ful}, 1);
    step();
    rv = 1; rdata = 32'h1111_1111; iv = 1;
    qa.push_back('{rd: 5'd8, d: 32'h8888_8888});
    smp();
    chk("full_pop_nostall", {31'd0, sfull}, 0);
    chk("full_pop_stall_any", {31'd0, st}, 0);
    step();
    idle(); smp();
    chk("full_cnt_kept", {29'd0, cnt}, 4);
    chk("full_flag_kept", {31'd0, ful}, 1);
    step();
    for (int j = 0; j < 4; j++) begin
      idle(); rv = 1; rdata = drain[j];
      smp(); step();
    end
    idle(); smp();
    chk("full_drained_cnt", {29'd0, cnt}, 0);
    step();

    // WAW: load x7 then addi x7,x0,1
    idle(); load_a(7, 32'h0000_0077);
    smp(); step();
    idle(); iwr = 1; ird = 7; rs1 = 0; u1 = 1;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("waw_stall", {31'd0, swaw}, 1);
      chk("waw_no_raw", {31'd0, sraw}, 0);
      step();
    end
    rv = 1; rdata = 32'h0000_0077; iv = 1;
    smp();
    chk("waw_resolve", {31'd0, swaw}, 0);
    chk("waw_resolve_stall", {31'd0, st}, 0);
    step();
    idle(); smp();
    chk("waw_cnt_after", {29'd0, cnt}, 0);
    step();

    // Load to x0: queued, never pending, no writeback
    idle(); iv = 1; ild = 1; iwr = 1; ird = 0;
    smp(); step();
    idle(); iwr = 1; ird = 0; rs1 = 0; rs2 = 0; u1 = 1; u2 = 1;
    smp();
    chk("x0_no_stall", {31'd0, st}, 0);
    chk("x0_cnt", {29'd0, cnt}, 1);
    step();
    idle(); rv = 1; rdata = 32'h0000_ABCD;
    smp(); chk("x0_no_wb", {31'd0, wbv}, 0);
    step();
    idle(); smp();
    chk("x0_cnt_after", {29'd0, cnt}, 0);
    chk("x0_empty_after", {31'd0, emp}, 1);
    step();

    // Same-cycle pop and push to the same rd keeps it pending
    idle(); load_a(9, 32'h0000_0099);
    smp(); step();
    idle(); rv = 1; rdata = 32'h0000_0099; load_a(9, 32'h0000_009A);
    smp(); chk("same_rd_no_stall", {31'd0, st}, 0);
    step();
    idle(); rs1 = 9; u1 = 1;
    smp();
    chk("same_rd_pending", {31'd0, sraw}, 1);
    chk("same_rd_cnt", {29'd0, cnt}, 1);
    step();
    idle(); rv = 1; rdata = 32'h0000_009A; rs1 = 9; u1 = 1;
    smp();
    chk("same_rd_fwd", {31'd0, f1}, 1);
    chk("same_rd_raw_clear", {31'd0, sraw}, 0);
    step();
    idle(); smp();
    chk("same_rd_cnt_after", {29'd0, cnt}, 0);
    step();

    // Stray response: sticky protocol_err; async reset clears immediately
    idle(); rv = 1; rdata = 32'h5555_5555;
    smp(); chk("stray_no_wb", {31'd0, wbv}, 0);
    step();
    idle(); smp();
    chk("perr_set", {31'd0, perr}, 1);
    chk("perr_cnt", {29'd0, cnt}, 0);
    step(); step();
    smp(); chk("perr_sticky", {31'd0, perr}, 1);
    step();
    idle(); load_a(3, 32'h0000_0033);
    smp(); step();
    idle();
    #1 rst_n = 0;
    qa.delete();
    #1;
    chk("async_rst_perr", {31'd0, perr}, 0);
    chk("async_rst_cnt", {29'd0, cnt}, 0);
    chk("async_rst_empty", {31'd0, emp}, 1);
    #1 rst_n = 1;
    step();
    idle(); rv = 1; rdata = 32'h0000_0033;
    smp(); chk("post_rst_no_wb", {31'd0, wbv}, 0);
    step();
    idle(); smp();
    chk("post_rst_perr", {31'd0, perr}, 1);
    chk("post_rst_cnt", {29'd0, cnt}, 0);
    #1 rst_n = 0;
    #1 rst_n = 1;
    step();

    // MAX_OUTSTANDING=3: 10 loads, responses 3 cycles behind, pointers wrap
    for (int k = 0; k < 13; k++) begin
      idle();
      if (k < 10) begin
        iv2 = 1; ild2 = 1; iwr2 = 1; ird2 = 5'(10 + k);
        qb.push_back('{rd: 5'(10 + k), d: 32'h1000 + k});
      end
      if (k >= 3) begin
        rv2 = 1; rdata2 = 32'h1000 + (k - 3);
      end
      smp();
      if (k >= 3) begin
        chk("wrap_no_full_stall", {31'd0, sfull2}, 0);
        chk("wrap_no_stall", {31'd0, st2}, 0);
      end
      step();
      if (k >= 2 && k < 10) chk("wrap_cnt_full", {30'd0, cnt2}, 3);
    end
    idle(); smp();
    chk("wrap_cnt_after", {30'd0, cnt2}, 0);
    chk("wrap_empty_after", {31'd0, emp2}, 1);
    step();

    chk("a_all_wb_seen", qa.size(), 0);
    chk("b_all_wb_seen", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
